gpio_bank_regs: RTL and testbench

Parametrised GPIO register bank for the HM3 bus fabric. It owns the data, set/clear, direction, open-drain, source-select and pin-interrupt registers for `NumGPIO` connectors of `GPIOWidth` pins each, and drives per-pin output and enable to the pad wrapper. Pin inputs are synchronised, edge-detected and gathered into a sticky write-1-to-clear status with one interrupt line. Reads of unmapped addresses return `busdata_fromhm2`, so the block sits in front of the hostmot2 read path.

---
 rtl/gpio_bank_regs.sv | 178 +++++++++++++++++
 tb/tb_gpio_bank_regs.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank_regs.sv
// GPIO register bank: pin data/direction/open-drain/source registers plus edge-detected sticky status and irq.
// Bus latency 2 (register update at E1, read data at E2), one access per cycle, no backpressure.
module gpio_bank_regs #(
    parameter int AddrWidth  = 16,
    parameter int BusWidth   = 32,
    parameter int GPIOWidth  = 36,
    parameter int NumGPIO    = 2,
    parameter int IoRegWidth = 24,
    parameter int SyncStages = 2
) (
    input  logic                         reg_clk,
    input  logic                         reset_in,
    input  logic                         chip_sel,
    input  logic                         write_reg,
    input  logic                         read_reg,
    input  logic [AddrWidth-3:0]         busaddress,
    input  logic [BusWidth-1:0]          busdata_in,
    input  logic [BusWidth-1:0]          busdata_fromhm2,
    input  logic [GPIOWidth*NumGPIO-1:0] iodatafromhm3,
    input  logic [GPIOWidth*NumGPIO-1:0] gpio_in,
    output logic [GPIOWidth*NumGPIO-1:0] gpio_out,
    output logic [GPIOWidth*NumGPIO-1:0] gpio_oe,
    output logic [BusWidth-1:0]          busdata_to_cpu,
    output logic                         read_valid,
    output logic                         irq
);
    localparam int NB = GPIOWidth * NumGPIO;
    localparam int NR = (NB + IoRegWidth - 1) / IoRegWidth;
    localparam int NP = NR * IoRegWidth;
    localparam int AW = AddrWidth - 2;

    // Word address splits into a 64-byte block selector and a 4-bit register index.
    typedef logic [AW-5:0] blk_t;
    localparam blk_t BLK_IO   = blk_t'(32'h040);
    localparam blk_t BLK_SET  = blk_t'(32'h041);
    localparam blk_t BLK_CLR  = blk_t'(32'h042);
    localparam blk_t BLK_DDR  = blk_t'(32'h044);
    localparam blk_t BLK_SRC  = blk_t'(32'h048);
    localparam blk_t BLK_OD   = blk_t'(32'h04C);
    localparam blk_t BLK_RISE = blk_t'(32'h050);
    localparam blk_t BLK_FALL = blk_t'(32'h051);
    localparam blk_t BLK_STAT = blk_t'(32'h052);

    logic                  wr_q, rd_q;
    logic [AW-1:0]         addr_q;
    logic [IoRegWidth-1:0] wdat_q;
    logic [NB-1:0]         io_q, ddr_q, src_q, od_q, rise_q, fall_q, stat_q;
    logic [NB-1:0]         io_d, ddr_d, src_d, od_d, rise_d, fall_d, stat_d;
    logic [SyncStages-1:0][NB-1:0] sync_q;
    logic [NB-1:0]         in_s, in_p_q, ev;
    logic [NB-1:0]         pin_d, out_q, oe_q, out_d, oe_d;
    logic                  irq_q, rv1_q, rv2_q;
    logic [BusWidth-1:0]   rdata_d, rdata1_q, bus_q;
    blk_t                  blk;
    logic [3:0]            k;
    logic                  k_ok;
    int                    sh;
    logic [NB-1:0]         wsel, wdat;
    logic                  unused_bus_hi;

    assign unused_bus_hi = ^busdata_in[BusWidth-1:IoRegWidth];

    assign blk  = addr_q[AW-1:4];
    assign k    = addr_q[3:0];
    assign k_ok = int'(k) < NR;
    assign sh   = int'(k) * IoRegWidth;
    assign wsel = NB'(NP'({IoRegWidth{1'b1}}) << sh);
    assign wdat = NB'(NP'(wdat_q) << sh);

    function automatic logic [BusWidth-1:0] pick(input logic [NB-1:0] v, input int s);
        return BusWidth'(IoRegWidth'(NP'(v) >> s));
    endfunction

    assign in_s = sync_q[SyncStages-1];
    assign ev   = (in_s & ~in_p_q & rise_q) | (~in_s & in_p_q & fall_q);

    always_comb begin
        io_d   = io_q;
        ddr_d  = ddr_q;
        src_d  = src_q;
        od_d   = od_q;
        rise_d = rise_q;
        fall_d = fall_q;
        stat_d = stat_q;
        if (wr_q && k_ok) begin
            case (blk)
                BLK_IO:   io_d   = (io_q & ~wsel) | wdat;
                BLK_SET:  io_d   = io_q | wdat;
                BLK_CLR:  io_d   = io_q & ~wdat;
                BLK_DDR:  ddr_d  = (ddr_q & ~wsel) | wdat;
                BLK_SRC:  src_d  = (src_q & ~wsel) | wdat;
                BLK_OD:   od_d   = (od_q & ~wsel) | wdat;
                BLK_RISE: rise_d = (rise_q & ~wsel) | wdat;
                BLK_FALL: fall_d = (fall_q & ~wsel) | wdat;
                BLK_STAT: stat_d = stat_q & ~wdat;
                default:  ;
            endcase
        end
        // A fresh edge beats a same-cycle W1C of the same bit.
        stat_d = stat_d | ev;
    end

    always_comb begin
        rdata_d = busdata_fromhm2;
        if (k_ok) begin
            case (blk)
                BLK_IO:           rdata_d = pick(in_s, sh);
                BLK_SET, BLK_CLR: rdata_d = '0;
                BLK_DDR:          rdata_d = pick(ddr_q, sh);
                BLK_SRC:          rdata_d = pick(src_q, sh);
                BLK_OD:           rdata_d = pick(od_q, sh);
                BLK_RISE:         rdata_d = pick(rise_q, sh);
                BLK_FALL:         rdata_d = pick(fall_q, sh);
                BLK_STAT:         rdata_d = pick(stat_q, sh);
                default:          rdata_d = busdata_fromhm2;
            endcase
        end
    end

    // Open-drain pins only ever pull low: enable the driver when the data bit is 0.
    assign pin_d = (src_q & iodatafromhm3) | (~src_q & io_q);
    assign out_d = ~od_q & pin_d;
    assign oe_d  = (od_q & ~pin_d) | (~od_q & ddr_q);

    always_ff @(posedge reg_clk or posedge reset_in) begin
        if (reset_in) begin
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= '0;
            io_q     <= '0;
            ddr_q    <= '0;
            src_q    <= '1;
            od_q     <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            stat_q   <= '0;
            sync_q   <= '0;
            in_p_q   <= '0;
            out_q    <= '0;
            oe_q     <= '0;
            irq_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rdata1_q <= '0;
            rv2_q    <= 1'b0;
            bus_q    <= '0;
        end else begin
            wr_q     <= write_reg & chip_sel;
            rd_q     <= read_reg & chip_sel;
            addr_q   <= busaddress;
            wdat_q   <= busdata_in[IoRegWidth-1:0];
            io_q     <= io_d;
            ddr_q    <= ddr_d;
            src_q    <= src_d;
            od_q     <= od_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            stat_q   <= stat_d;
            sync_q   <= {sync_q[SyncStages-2:0], gpio_in};
            in_p_q   <= in_s;
            out_q    <= out_d;
            oe_q     <= oe_d;
            irq_q    <= |stat_q;
            rv1_q    <= rd_q;
            rdata1_q <= rdata_d;
            rv2_q    <= rv1_q;
            if (rv1_q) begin
                bus_q <= rdata1_q;
            end
        end
    end

    assign gpio_out       = out_q;
    assign gpio_oe        = oe_q;
    assign busdata_to_cpu = bus_q;
    assign read_valid     = rv2_q;
    assign irq            = irq_q;
endmodule

// File: tb/tb_gpio_bank_regs.sv
// Bench for gpio_bank_regs: word-level register model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_gpio_bank_regs;
    localparam int NB = 72, NR = 3, RW = 24, SYNC = 2;
    localparam logic [71:0] HM3 = 72'hC3_A5A5A5A5_5A5A5A5A;
    localparam int KIO = 0, KDDR = 1, KSRC = 2, KOD = 3, KRISE = 4, KFALL = 5, KSTAT = 6, KSET = 7, KCLR = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cs, wr, rd;
    logic [13:0]   addr;
    logic [31:0]   wdat, hm2;
    logic [NB-1:0] hm3, gin, gout, goe;
    logic [31:0]   rdat;
    logic          rv, irq;
    int            checks = 0, failures = 0;

    always #5 clk = ~clk;

    gpio_bank_regs dut (
        .reg_clk(clk), .reset_in(rst), .chip_sel(cs), .write_reg(wr), .read_reg(rd),
        .busaddress(addr), .busdata_in(wdat), .busdata_fromhm2(hm2),
        .iodatafromhm3(hm3), .gpio_in(gin), .gpio_out(gout), .gpio_oe(goe),
        .busdata_to_cpu(rdat), .read_valid(rv), .irq(irq)
    );

    // Model: registers as 24-bit words per kind, pins derived bit by bit.
    logic [RW-1:0] mreg [0:6][0:NR-1];
    logic [NB-1:0] m_hist [0:SYNC-1];
    logic [NB-1:0] m_inp, e_out, e_oe;
    logic          p_wr, p_rd, m_rv1, e_irq, e_rv;
    int            p_addr;
    logic [31:0]   p_data, m_rd1, e_bus;

    function automatic logic pin(input int kind, input int p);
        return mreg[kind][p / RW][p % RW];
    endfunction

    function automatic int decode(input int a, output int k);
        int base;
        k = (a >> 2) & 15;
        base = a & ~32'h3F;
        if (k >= NR) return -1;
        case (base)
            32'h1000: return KIO;
            32'h1040: return KSET;
            32'h1080: return KCLR;
            32'h1100: return KDDR;
            32'h1200: return KSRC;
            32'h1300: return KOD;
            32'h1400: return KRISE;
            32'h1440: return KFALL;
            32'h1480: return KSTAT;
            default:  return -1;
        endcase
    endfunction

    function automatic logic [31:0] read_word(input int a, input logic [NB-1:0] ins, input logic [31:0] pass);
        int k, kind;
        kind = decode(a, k);
        if (kind < 0) return pass;
        if (kind == KIO) return 32'(ins[k*RW +: RW]);
        if (kind == KSET || kind == KCLR) return 32'h0;
        return 32'(mreg[kind][k]);
    endfunction

    task automatic model_reset();
        for (int kd = 0; kd < 7; kd++)
            for (int j = 0; j < NR; j++) mreg[kd][j] = (kd == KSRC) ? '1 : '0;
        for (int s = 0; s < SYNC; s++) m_hist[s] = '0;
        m_inp = '0; e_out = '0; e_oe = '0; e_irq = 1'b0; e_rv = 1'b0; e_bus = '0;
        p_wr = 1'b0; p_rd = 1'b0; p_addr = 0; p_data = '0; m_rv1 = 1'b0; m_rd1 = '0;
    endtask

    task automatic model_step();
        logic [NB-1:0] ins, ev;
        logic          d;
        int            kind, k;
        ins = m_hist[SYNC-1];
        for (int p = 0; p < NB; p++) begin
            d = pin(KSRC, p) ? hm3[p] : pin(KIO, p);
            e_out[p] = pin(KOD, p) ? 1'b0 : d;
            e_oe[p]  = pin(KOD, p) ? ~d : pin(KDDR, p);
        end
        e_irq = 1'b0;
        for (int j = 0; j < NR; j++) if (mreg[KSTAT][j] != '0) e_irq = 1'b1;
        e_rv = m_rv1;
        if (m_rv1) e_bus = m_rd1;
        m_rv1 = p_rd;
        if (p_rd) m_rd1 = read_word(p_addr, ins, hm2);
        for (int p = 0; p < NB; p++)
            ev[p] = (ins[p] & ~m_inp[p] & pin(KRISE, p)) | (~ins[p] & m_inp[p] & pin(KFALL, p));
        if (p_wr) begin
            kind = decode(p_addr, k);
            case (kind)
                KIO:   mreg[KIO][k] = p_data[RW-1:0];
                KSET:  mreg[KIO][k] = mreg[KIO][k] | p_data[RW-1:0];
                KCLR:  mreg[KIO][k] = mreg[KIO][k] & ~p_data[RW-1:0];
                KSTAT: mreg[KSTAT][k] = mreg[KSTAT][k] & ~p_data[RW-1:0];
                KDDR, KSRC, KOD, KRISE, KFALL: mreg[kind][k] = p_data[RW-1:0];
                default: ;
            endcase
        end
        for (int j = 0; j < NR; j++) mreg[KSTAT][j] = mreg[KSTAT][j] | ev[j*RW +: RW];
        m_inp = ins;
        for (int s = SYNC - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
        m_hist[0] = gin;
        p_wr = wr & cs;
        p_rd = rd & cs;
        p_addr = int'({addr, 2'b00});
        p_data = wdat;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else model_step();
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("gpio_out", 96'(gout), 96'(e_out));
            chk("gpio_oe", 96'(goe), 96'(e_oe));
            chk("irq", 96'(irq), 96'(e_irq));
            chk("read_valid", 96'(rv), 96'(e_rv));
            chk("busdata_to_cpu", 96'(rdat), 96'(e_bus));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic op(input logic w, input logic r, input logic c, input int a, input logic [31:0] d);
        cs = c; wr = w; rd = r; addr = 14'(a >> 2); wdat = d;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; cs = 1'b0;
    endtask

    task automatic write(input int a, input logic [31:0] d);
        op(1'b1, 1'b0, 1'b1, a, d);
    endtask

    // read_valid must pulse exactly once, on the third negedge after the strobe edge.
    task automatic read_chk(input string name, input int a, input logic [31:0] exp,
                            input logic w = 1'b0, input logic [31:0] wd = 32'h0);
        int idx, cnt;
        logic [31:0] got;
        idx = -1; cnt = 0; got = '0;
        op(w, 1'b1, 1'b1, a, wd);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rv === 1'b1) begin
                cnt++;
                idx = i;
                got = rdat;
            end
        end
        chk({name, "_timing"}, 96'(cnt * 16 + idx), 96'(1 * 16 + 2));
        chk(name, 96'(got), 96'(exp));
    endtask

    initial begin
        rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdat = '0;
        hm2 = 32'h0; hm3 = HM3; gin = '1;
        cyc(3);
        rst = 1'b0;
        chk("rst_gpio_oe", 96'(goe), 96'(0));
        chk("rst_gpio_out", 96'(gout), 96'(0));
        chk("rst_irq", 96'(irq), 96'(0));
        chk("rst_busdata", 96'(rdat), 96'(0));
        cyc(1);
        chk("src_default_out", 96'(gout), 96'(HM3));
        read_chk("src0_reset", 32'h1200, 32'h00FF_FFFF);
        read_chk("pins0_ones", 32'h1000, 32'h00FF_FFFF);
        read_chk("ddr2_reset", 32'h1108, 32'h0);
        gin = '0;
        cyc(4);

        write(32'h1200, 32'h0);
        write(32'h1100, 32'hF);
        write(32'h1000, 32'h5);
        write(32'h1040, 32'hA);
        write(32'h1080, 32'h1);
        cyc(1);
        chk("clr_out_e1", 96'(gout[3:0]), 96'(4'hF));
        cyc(1);
        chk("clr_out_e2", 96'(gout[3:0]), 96'(4'hE));
        chk("clr_oe_e2", 96'(goe[3:0]), 96'(4'hF));
        gin[3:0] = 4'hE;
        cyc(3);
        read_chk("io0_pins", 32'h1000, 32'h0000_000E);
        read_chk("set_reads0", 32'h1040, 32'h0);

        write(32'h1300, 32'h1);
        write(32'h1040, 32'h1);
        cyc(2);
        chk("od_hi_oe", 96'(goe[0]), 96'(0));
        chk("od_hi_out", 96'(gout[0]), 96'(0));
        write(32'h1100, 32'hE);
        write(32'h1080, 32'h1);
        cyc(2);
        chk("od_lo_oe", 96'(goe[0]), 96'(1));
        chk("od_lo_out", 96'(gout[0]), 96'(0));

        op(1'b1, 1'b0, 1'b0, 32'h1100, 32'h55);
        read_chk("cs_gated", 32'h1100, 32'h0000_000E);
        read_chk("rw_pre", 32'h1100, 32'h0000_000E, 1'b1, 32'h123);
        read_chk("rw_post", 32'h1100, 32'h0000_0123);
        write(32'h1104, 32'hFF00_0001);
        read_chk("high_bits_dropped", 32'h1104, 32'h0000_0001);
        hm2 = 32'hCAFE_F00D;
        read_chk("k_beyond_nr", 32'h110C, 32'hCAFE_F00D);
        hm2 = 32'hDEAD_BEEF;
        read_chk("unmapped", 32'h0200, 32'hDEAD_BEEF);

        write(32'h1404, 32'h0001_0000);
        cyc(2);
        gin[40] = 1'b1;
        cyc(3);
        chk("irq_before_p3", 96'(irq), 96'(0));
        cyc(1);
        chk("irq_at_p3", 96'(irq), 96'(1));
        read_chk("stat1_rise", 32'h1484, 32'h0001_0000);
        read_chk("stat0_clean", 32'h1480, 32'h0);
        gin[40] = 1'b0;
        cyc(4);
        read_chk("fall_ignored", 32'h1484, 32'h0001_0000);

        @(posedge clk);
        #1;
        gin[40] = 1'b1;
        cyc(1);
        write(32'h1484, 32'h0001_0000);
        cyc(1);
        chk("set_wins_irq", 96'(irq), 96'(1));
        cyc(2);
        chk("set_wins_irq_hold", 96'(irq), 96'(1));
        read_chk("set_wins_stat", 32'h1484, 32'h0001_0000);
        write(32'h1484, 32'h0001_0000);
        cyc(1);
        chk("w1c_irq_e1", 96'(irq), 96'(1));
        cyc(1);
        chk("w1c_irq_e2", 96'(irq), 96'(0));
        read_chk("w1c_stat", 32'h1484, 32'h0);

        read_chk("src1", 32'h1204, 32'h00FF_FFFF);
        op(1'b0, 1'b1, 1'b1, 32'h1204, 32'h0);
        cyc(1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_midread_rv", 96'(rv), 96'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_midread_bus", 96'(rdat), 96'(0));
        cyc(4);
        chk("rst_midread_rv_after", 96'(rv), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
